// File: rtl/lavadora_sched.sv
// Round-robin scheduler that shares one wash unit among N_REQ paid stations,
// timing wash / heavy / wash+dry programs and reporting completion per station.
module lavadora_sched #(
  parameter int N_REQ    = 4,
  parameter int T_LAVADO = 8,
  parameter int T_PESADO = 12,
  parameter int T_SECADO = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [2*N_REQ-1:0]       PROG,
  input  logic                     CANCEL,
  output logic [N_REQ-1:0]         GNT,
  output logic                     LAVADO,
  output logic                     LAVADO_PESADO,
  output logic                     SECADO,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ABORTED,
  output logic [$clog2(N_REQ)-1:0] DONE_ID
);

  localparam int IW    = $clog2(N_REQ);
  localparam int T_MAX = (T_LAVADO > T_PESADO)
                         ? ((T_LAVADO > T_SECADO) ? T_LAVADO : T_SECADO)
                         : ((T_PESADO > T_SECADO) ? T_PESADO : T_SECADO);
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [1:0] PROG_NONE     = 2'b00;
  localparam logic [1:0] PROG_HEAVY    = 2'b10;
  localparam logic [1:0] PROG_WASH_DRY = 2'b11;

  localparam logic [CW-1:0] LD_LAVADO = CW'(T_LAVADO - 1);
  localparam logic [CW-1:0] LD_PESADO = CW'(T_PESADO - 1);
  localparam logic [CW-1:0] LD_SECADO = CW'(T_SECADO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_served;
  logic [1:0]      r_prog;
  logic [CW-1:0]   r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic            r_lavado;
  logic            r_pesado;
  logic            r_secado;
  logic            r_busy;
  logic            r_done;
  logic            r_aborted;
  logic [IW-1:0]   r_done_id;

  logic [1:0]       w_prog [N_REQ];
  logic [N_REQ-1:0] w_valid;
  logic             w_found;
  logic [IW-1:0]    w_sel;
  logic [1:0]       w_sel_prog;
  logic [IW:0]      w_sum;
  logic [N_REQ-1:0] w_onehot;
  logic             w_to_dry;
  logic             w_finish;
  logic [IW-1:0]    w_ptr_next;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_prog[i]  = PROG[2*i +: 2];
      w_valid[i] = REQ[i] && (PROG[2*i +: 2] != PROG_NONE);
    end
  end

  // Search from r_ptr upward with wraparound; the first valid station wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_found    = 1'b0;
    w_sel      = '0;
    w_sel_prog = PROG_NONE;
    w_sum      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N_REQ)) begin
        w_sum = w_sum - (IW+1)'(N_REQ);
      end
      if (!w_found && w_valid[w_sum[IW-1:0]]) begin
        w_found    = 1'b1;
        w_sel      = w_sum[IW-1:0];
        w_sel_prog = w_prog[w_sum[IW-1:0]];
      end
    end
  end

  assign w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_ptr_next = (r_served == IW'(N_REQ - 1)) ? '0 : r_served + 1'b1;

  // Cancel outranks the wash-to-dry hand-off at the same edge.
  assign w_to_dry = (r_prog == PROG_WASH_DRY) && r_lavado && (r_cnt == '0);
  assign w_finish = (r_state == S_RUN) && (CANCEL || ((r_cnt == '0) && !w_to_dry));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_served  <= '0;
      r_prog    <= PROG_NONE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_lavado  <= 1'b0;
      r_pesado  <= 1'b0;
      r_secado  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_done_id <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_gnt    <= w_onehot;
            r_served <= w_sel;
            r_prog   <= w_sel_prog;
            if (w_sel_prog == PROG_HEAVY) begin
              r_pesado <= 1'b1;
              r_cnt    <= LD_PESADO;
            end else begin
              r_lavado <= 1'b1;
              r_cnt    <= LD_LAVADO;
            end
          end
        end

        S_RUN: begin
          if (w_finish) begin
            r_state   <= S_FIN;
            r_gnt     <= '0;
            r_lavado  <= 1'b0;
            r_pesado  <= 1'b0;
            r_secado  <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= CANCEL;
            r_done_id <= r_served;
          end else if (w_to_dry) begin
            r_lavado <= 1'b0;
            r_secado <= 1'b1;
            r_cnt    <= LD_SECADO;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_FIN: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_done_id <= '0;
          r_ptr     <= w_ptr_next;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign GNT           = r_gnt;
  assign LAVADO        = r_lavado;
  assign LAVADO_PESADO = r_pesado;
  assign SECADO        = r_secado;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign ABORTED       = r_aborted;
  assign DONE_ID       = r_done_id;

endmodule

// File: tb/tb_lavadora_sched.sv
// Bench for lavadora_sched at default parameters: a cycle-by-cycle vector table
// for reset/cancel/pointer behaviour plus directed multi-cycle program runs.
module tb_lavadora_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] REQ;
  logic [7:0] PROG;
  logic       CANCEL;
  logic [3:0] GNT;
  logic       LAVADO;
  logic       LAVADO_PESADO;
  logic       SECADO;
  logic       BUSY;
  logic       DONE;
  logic       ABORTED;
  logic [1:0] DONE_ID;

  int errors = 0;
  int checks = 0;

  lavadora_sched dut (
    .clk           (clk),
    .rst           (rst),
    .REQ           (REQ),
    .PROG          (PROG),
    .CANCEL        (CANCEL),
    .GNT           (GNT),
    .LAVADO        (LAVADO),
    .LAVADO_PESADO (LAVADO_PESADO),
    .SECADO        (SECADO),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ABORTED       (ABORTED),
    .DONE_ID       (DONE_ID)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Packed observation: {GNT[3:0], LAVADO, PESADO, SECADO, BUSY, DONE, ABORTED, DONE_ID[1:0]}
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  prog;
    logic        cancel;
    logic [11:0] exp;
    string       name;
  } vec_t;

  function automatic logic [11:0] obs();
    return {GNT, LAVADO, LAVADO_PESADO, SECADO, BUSY, DONE, ABORTED, DONE_ID};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starting at a grant cycle, step until DONE and tally the phase windows.
  task automatic run_check(input string name, input int exp_lav, input int exp_pes,
                           input int exp_sec, input logic [1:0] exp_id,
                           input logic exp_ab, input int exp_steps);
    int   n_lav, n_pes, n_sec, n_steps;
    logic bad, seen_sec;
    n_lav = 0; n_pes = 0; n_sec = 0; n_steps = 0;
    bad = 1'b0; seen_sec = 1'b0;
    while (!DONE && n_steps < 100) begin
      if (int'(LAVADO) + int'(LAVADO_PESADO) + int'(SECADO) != 1) bad = 1'b1;
      if (LAVADO && seen_sec) bad = 1'b1;
      if (SECADO) seen_sec = 1'b1;
      n_lav += int'(LAVADO);
      n_pes += int'(LAVADO_PESADO);
      n_sec += int'(SECADO);
      step();
      n_steps++;
    end
    check({name, "_done_seen"}, 32'(DONE), 32'd1);
    check({name, "_lavado_len"}, n_lav, exp_lav);
    check({name, "_pesado_len"}, n_pes, exp_pes);
    check({name, "_secado_len"}, n_sec, exp_sec);
    check({name, "_cycles_to_done"}, n_steps, exp_steps);
    check({name, "_phase_shape"}, 32'(bad), 32'd0);
    check({name, "_done_cycle"}, 32'({GNT, LAVADO, LAVADO_PESADO, SECADO, BUSY, ABORTED, DONE_ID}),
          32'({4'b0000, 3'b000, 1'b1, exp_ab, exp_id}));
  endtask

  vec_t vecs[12];
  int   gap;

  initial begin
    rst = 1'b1; REQ = '0; PROG = '0; CANCEL = 1'b0;

    vecs[0]  = '{1'b1, 4'hF, 8'h55, 1'b0, 12'h000, "rst_cycle0"};
    vecs[1]  = '{1'b1, 4'hF, 8'h55, 1'b0, 12'h000, "rst_cycle1"};
    vecs[2]  = '{1'b0, 4'hF, 8'h55, 1'b0, 12'h190, "release_grant0"};
    vecs[3]  = '{1'b0, 4'h0, 8'h55, 1'b0, 12'h190, "run_cycle2"};
    vecs[4]  = '{1'b0, 4'h0, 8'h55, 1'b0, 12'h190, "run_cycle3"};
    vecs[5]  = '{1'b0, 4'h0, 8'h55, 1'b1, 12'h01C, "cancel_fin"};
    vecs[6]  = '{1'b0, 4'h0, 8'h55, 1'b0, 12'h000, "cancel_idle"};
    vecs[7]  = '{1'b0, 4'hF, 8'h55, 1'b0, 12'h290, "ptr_advanced"};
    vecs[8]  = '{1'b1, 4'h0, 8'h55, 1'b0, 12'h000, "midrun_reset"};
    vecs[9]  = '{1'b0, 4'hF, 8'h55, 1'b0, 12'h190, "post_reset_grant0"};
    vecs[10] = '{1'b1, 4'h0, 8'h55, 1'b0, 12'h000, "reset_again"};
    vecs[11] = '{1'b0, 4'h0, 8'h55, 1'b0, 12'h000, "idle_clean"};

    for (int v = 0; v < 12; v++) begin
      rst = vecs[v].rst; REQ = vecs[v].req; PROG = vecs[v].prog; CANCEL = vecs[v].cancel;
      step();
      check(vecs[v].name, 32'(obs()), 32'(vecs[v].exp));
    end
    CANCEL = 1'b0;

    // Single wash on station 2.
    REQ = 4'b0100; PROG = 8'b0001_0000;
    step();
    check("wash_grant", 32'({GNT, LAVADO, BUSY}), 32'({4'b0100, 1'b1, 1'b1}));
    REQ = '0;
    run_check("wash", 8, 0, 0, 2'd2, 1'b0, 8);
    step();
    step();
    check("wash_busy_after", 32'(BUSY), 32'd0);

    // Wash followed by dry on station 1.
    REQ = 4'b0010; PROG = 8'b0000_1100;
    step();
    check("wdry_grant", 32'({GNT, LAVADO}), 32'({4'b0010, 1'b1}));
    REQ = '0;
    run_check("wdry", 8, 0, 6, 2'd1, 1'b0, 14);
    step();

    // Cancel on the last wash cycle of a wash+dry must beat the dry hand-off.
    REQ = 4'b0100; PROG = 8'b0011_0000;
    step();
    check("cprio_grant", 32'(GNT), 32'b0100);
    REQ = '0;
    repeat (7) step();
    check("cprio_last_wash", 32'({LAVADO, SECADO}), 32'b10);
    CANCEL = 1'b1;
    step();
    CANCEL = 1'b0;
    check("cprio_fin", 32'(obs()), 32'h01E);
    step();

    // Round-robin with every station holding a heavy request.
    rst = 1'b1;
    step();
    rst = 1'b0; REQ = 4'hF; PROG = 8'hAA;
    step();
    for (int s = 0; s < 5; s++) begin
      check($sformatf("rr_grant%0d", s), 32'(GNT), 32'(4'b0001 << (s % 4)));
      run_check($sformatf("rr_run%0d", s), 0, 12, 0, 2'(s % 4), 1'b0, 12);
      if (s < 4) begin
        gap = 0;
        while (GNT == '0 && gap < 10) begin
          gap++;
          step();
        end
        check($sformatf("rr_gap%0d", s), gap, 2);
      end
    end
    REQ = '0;
    step();
    step();

    // Invalid program never granted; a request raised mid-run waits its turn.
    REQ = 4'b0001; PROG = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("invalid_idle%0d", k), 32'(obs()), 32'h000);
    end
    REQ = 4'b0011; PROG = 8'b0000_0100;
    step();
    check("inv_grant1", 32'(GNT), 32'b0010);
    REQ = 4'b1011; PROG = 8'b1000_0100;
    run_check("inv_run1", 8, 0, 0, 2'd1, 1'b0, 8);
    step();
    step();
    check("late_grant3", 32'({GNT, LAVADO_PESADO}), 32'({4'b1000, 1'b1}));
    run_check("late_run3", 0, 12, 0, 2'd3, 1'b0, 12);
    REQ = 4'b0001; PROG = '0;
    step();
    step();
    step();
    check("invalid_never", 32'(obs()), 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
